// File: rtl/bcd_rtc_core.sv
// bcd_rtc_core
//   BCD time-of-day core (HH:MM:SS) with an internal seconds prescaler,
//   selectable 12/24-hour counting and in-place time setting.
//
// Parameters
//   PRESCALE  clk cycles per second (>= 1; 1 advances every cycle)
//   H24       1: hours 00..23, 0: hours 01..12 plus pm flag
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   pause_tgl, sel_next, inc_digit one-cycle button pulses
//   h2,h1,m2,m1,s2,s1             BCD time digits
//   pm                            PM flag (12 h mode only, else 0)
//   paused                        1 = set mode, time frozen
//   sel                           selected digit 0=s1 .. 5=h2
//   sec_pulse                     high the cycle after each advance
//
// Optional build macro RTC_ALARM_EN adds alarm_hhmm, alarm_pm, alarm_arm
// and alarm_hit; alarm_hit pulses with sec_pulse when a running advance
// lands on the alarm HH:MM:00 while armed.
//
// state  | meaning
// ST_RUN | time advances on each prescaler tick
// ST_SET | time frozen; sel_next/inc_digit edit a single digit
module bcd_rtc_core #(
  parameter int PRESCALE = 12000000,
  parameter int H24      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause_tgl,
  input  logic        sel_next,
  input  logic        inc_digit,
`ifdef RTC_ALARM_EN
  input  logic [15:0] alarm_hhmm,
  input  logic        alarm_pm,
  input  logic        alarm_arm,
  output logic        alarm_hit,
`endif
  output logic [3:0]  h2,
  output logic [3:0]  h1,
  output logic [3:0]  m2,
  output logic [3:0]  m1,
  output logic [3:0]  s2,
  output logic [3:0]  s1,
  output logic        pm,
  output logic        paused,
  output logic [2:0]  sel,
  output logic        sec_pulse
);

  localparam bit MODE24 = (H24 != 0);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_SET = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          pm_q;
  logic          tc;
  logic          adv;
  logic          edit;
  logic [3:0]    nh2, nh1, nm2, nm1, ns2, ns1;
  logic          npm;

  // 12 h hour sequence 12,01..11: shared by the carry chain and set mode.
  function automatic logic [7:0] hour12_inc(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd1 && o == 4'd2) return 8'h01;
    if (o == 4'd9)              return 8'h10;
    return {t, o + 4'd1};
  endfunction

  assign tc     = (cnt == CNT_LAST);
  // A pause_tgl cycle swallows any coincident tick or edit.
  assign adv    = (state == ST_RUN) && !pause_tgl && tc;
  assign edit   = (state == ST_SET) && !pause_tgl && inc_digit;
  assign paused = state[0];
  assign pm     = MODE24 ? 1'b0 : pm_q;

  always_comb begin
    {nh2, nh1, nm2, nm1, ns2, ns1} = {h2, h1, m2, m1, s2, s1};
    npm = pm_q;
    if (adv) begin
      if (s1 != 4'd9) ns1 = s1 + 4'd1;
      else begin
        ns1 = 4'd0;
        if (s2 != 4'd5) ns2 = s2 + 4'd1;
        else begin
          ns2 = 4'd0;
          if (m1 != 4'd9) nm1 = m1 + 4'd1;
          else begin
            nm1 = 4'd0;
            if (m2 != 4'd5) nm2 = m2 + 4'd1;
            else begin
              nm2 = 4'd0;
              if (MODE24) begin
                if (h2 == 4'd2 && h1 == 4'd3) begin
                  nh2 = 4'd0;
                  nh1 = 4'd0;
                end else if (h1 == 4'd9) begin
                  nh2 = h2 + 4'd1;
                  nh1 = 4'd0;
                end else begin
                  nh1 = h1 + 4'd1;
                end
              end else begin
                {nh2, nh1} = hour12_inc(h2, h1);
                // pm flips on the 11 -> 12 transition, not on 12 -> 01
                if (h2 == 4'd1 && h1 == 4'd1) npm = ~pm_q;
              end
            end
          end
        end
      end
    end else if (edit) begin
      case (sel)
        3'd0: ns1 = (s1 == 4'd9) ? 4'd0 : s1 + 4'd1;
        3'd1: ns2 = (s2 == 4'd5) ? 4'd0 : s2 + 4'd1;
        3'd2: nm1 = (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;
        3'd3: nm2 = (m2 == 4'd5) ? 4'd0 : m2 + 4'd1;
        3'd4: begin
          if (MODE24) begin
            if (h2 == 4'd2) nh1 = (h1 == 4'd3) ? 4'd0 : h1 + 4'd1;
            else            nh1 = (h1 == 4'd9) ? 4'd0 : h1 + 4'd1;
          end else begin
            {nh2, nh1} = hour12_inc(h2, h1);
          end
        end
        3'd5: begin
          if (MODE24) begin
            nh2 = (h2 == 4'd2) ? 4'd0 : h2 + 4'd1;
            // entering 2x: clamp ones so 24..29 can never appear
            if (h2 == 4'd1 && h1 > 4'd3) nh1 = 4'd3;
          end else begin
            npm = ~pm_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      cnt       <= '0;
      sel       <= 3'd0;
      sec_pulse <= 1'b0;
      h2        <= MODE24 ? 4'd0 : 4'd1;
      h1        <= MODE24 ? 4'd0 : 4'd2;
      m2        <= 4'd0;
      m1        <= 4'd0;
      s2        <= 4'd0;
      s1        <= 4'd0;
      pm_q      <= 1'b0;
    end else begin
      sec_pulse <= adv;
      if (pause_tgl) begin
        state <= (state == ST_RUN) ? ST_SET : ST_RUN;
        cnt   <= '0;
        if (state == ST_RUN) sel <= 3'd0;
      end else if (state == ST_SET) begin
        cnt <= '0;
        if (sel_next) sel <= (sel == 3'd5) ? 3'd0 : sel + 3'd1;
      end else begin
        cnt <= tc ? '0 : cnt + CW'(1);
      end
      {h2, h1, m2, m1, s2, s1} <= {nh2, nh1, nm2, nm1, ns2, ns1};
      pm_q <= npm;
    end
  end

`ifdef RTC_ALARM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_hit <= 1'b0;
    end else begin
      alarm_hit <= adv && alarm_arm
                   && ({nh2, nh1, nm2, nm1} == alarm_hhmm)
                   && (ns2 == 4'd0) && (ns1 == 4'd0)
                   && (MODE24 || (npm == alarm_pm));
    end
  end
`endif

endmodule
